// File: rtl/demux_scan_sequencer_if.sv
// demux_scan_sequencer_if: control inputs and demux-facing outputs of the scan sequencer
interface demux_scan_sequencer_if #(
  parameter int DWELL_W = 8,
  parameter int PASS_W  = 8
);
  logic               start;
  logic               stop;
  logic               continuous;
  logic [7:0]         chan_mask;
  logic [DWELL_W-1:0] dwell;
  logic               din;
  logic               i;
  logic [2:0]         S;
  logic               En;
  logic               busy;
  logic               done;
  logic [PASS_W-1:0]  pass_cnt;
  modport master (
    output start, stop, continuous, chan_mask, dwell, din,
    input  i, S, En, busy, done, pass_cnt
  );
  modport slave (
    input  start, stop, continuous, chan_mask, dwell, din,
    output i, S, En, busy, done, pass_cnt
  );
endinterface

// File: rtl/demux_scan_sequencer.sv
// demux_scan_sequencer: walks enabled channels of a 1-to-8 demux, holding each for a dwell time
module demux_scan_sequencer #(
  parameter int DWELL_W = 8,
  parameter int PASS_W  = 8
) (
  input logic clk,
  input logic rst_n,
  demux_scan_sequencer_if.slave bus
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t             state;
  logic [7:0]         mask_q;
  logic               cont_q;
  logic [DWELL_W-1:0] reload_q;
  logic [DWELL_W-1:0] cnt;
  logic [2:0]         nxt;
  logic               has_nxt;
  function automatic logic [2:0] lowest(input logic [7:0] m);
    lowest = '0;
    for (int k = 7; k >= 0; k--) if (m[k]) lowest = 3'(k);
  endfunction
  always_comb begin
    nxt = '0;
    has_nxt = 1'b0;
    for (int k = 7; k >= 0; k--)
      if (mask_q[k] && 3'(k) > bus.S) begin
        has_nxt = 1'b1;
        nxt = 3'(k);
      end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mask_q       <= '0;
      cont_q       <= 1'b0;
      reload_q     <= '0;
      cnt          <= '0;
      bus.i        <= 1'b0;
      bus.S        <= '0;
      bus.En       <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.pass_cnt <= '0;
    end else begin
      bus.i    <= bus.din;
      bus.done <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          bus.pass_cnt <= '0;
          if (bus.chan_mask != 8'd0) begin
            mask_q   <= bus.chan_mask;
            cont_q   <= bus.continuous;
            reload_q <= (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
            cnt      <= (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
            bus.S    <= lowest(bus.chan_mask);
            bus.En   <= 1'b1;
            bus.busy <= 1'b1;
            state    <= ACTIVE;
          end else
            bus.done <= 1'b1;
        end
      end else if (bus.stop) begin
        bus.En   <= 1'b0;
        bus.busy <= 1'b0;
        bus.S    <= '0;
        state    <= IDLE;
      end else if (cnt <= DWELL_W'(1)) begin
        // channel finished: advance, wrap, or close out the pass
        if (has_nxt) begin
          bus.S <= nxt;
          cnt   <= reload_q;
        end else if (cont_q) begin
          bus.S        <= lowest(mask_q);
          cnt          <= reload_q;
          bus.pass_cnt <= bus.pass_cnt + PASS_W'(1);
        end else begin
          bus.pass_cnt <= bus.pass_cnt + PASS_W'(1);
          bus.En       <= 1'b0;
          bus.busy     <= 1'b0;
          bus.S        <= '0;
          bus.done     <= 1'b1;
          state        <= IDLE;
        end
      end else
        cnt <= cnt - DWELL_W'(1);
    end
  end
endmodule

// File: tb/tb_demux_scan_sequencer.sv
// tb_demux_scan_sequencer: table-driven and randomized checks against a per-cycle schedule model
module tb_demux_scan_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic din_prev;
  demux_scan_sequencer_if #(.DWELL_W(8), .PASS_W(8)) bus();
  demux_scan_sequencer #(.DWELL_W(8), .PASS_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] mask;
    int dwell;
    bit cont;
    int stop_at;
    bit meddle;
    int exp_en;
    int exp_pass;
  } vec_t;
  vec_t vecs[7];
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step();
    din_prev = bus.din;
    @(posedge clk);
    #1;
    check("i_lag", int'(bus.i), int'(din_prev));
    bus.din = 1'($urandom);
  endtask
  task automatic check_out(input string tag, input int s, input int en, input int bsy, input int dn, input int pc);
    check({tag, "_S"}, int'(bus.S), s);
    check({tag, "_En"}, int'(bus.En), en);
    check({tag, "_busy"}, int'(bus.busy), bsy);
    check({tag, "_done"}, int'(bus.done), dn);
    check({tag, "_pass"}, int'(bus.pass_cnt), pc);
  endtask
  // Expected behaviour is a flat per-cycle list of channels for one pass; pass count is t/len.
  task automatic run_scan(input logic [7:0] m, input int d, input bit c, input int stop_at,
                          input bit meddle, output int en_cycles, output int last_pass);
    int q[$];
    int len;
    for (int ch = 0; ch < 8; ch++)
      if (m[ch]) for (int r = 0; r < (d == 0 ? 1 : d); r++) q.push_back(ch);
    len = q.size();
    en_cycles = 0;
    bus.chan_mask = m;
    bus.dwell = 8'(d);
    bus.continuous = c;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    if (len == 0) begin
      check_out("empty", 0, 0, 0, 1, 0);
      last_pass = int'(bus.pass_cnt);
      step();
      check_out("empty_after", 0, 0, 0, 0, 0);
      return;
    end
    for (int t = 0; ; t++) begin
      if (t > 4000) begin
        check("scan_timeout", t, 0);
        break;
      end
      if (stop_at >= 0 && t == stop_at + 1) begin
        check_out("stopped", 0, 0, 0, 0, stop_at / len);
        break;
      end
      if (!c && t == len) begin
        check_out("pass_end", 0, 0, 0, 1, 1);
        break;
      end
      check_out("active", q[t % len], 1, 1, 0, t / len);
      en_cycles += int'(bus.En);
      if (t == stop_at) bus.stop = 1'b1;
      if (meddle) begin
        bus.start = 1'b1;
        bus.chan_mask = 8'($urandom);
        bus.dwell = 8'($urandom);
        bus.continuous = 1'($urandom);
      end
      step();
      bus.stop = 1'b0;
      bus.start = 1'b0;
    end
    last_pass = int'(bus.pass_cnt);
    step();
    check("done_pulse_once", int'(bus.done), 0);
    check("idle_En", int'(bus.En), 0);
  endtask
  initial begin
    int en_c, lp, len, sa;
    logic [7:0] m;
    vecs[0] = '{8'hFF, 1, 1'b0, -1, 1'b0, 8, 1};
    vecs[1] = '{8'hA4, 3, 1'b0, -1, 1'b0, 9, 1};
    vecs[2] = '{8'h03, 0, 1'b1, 4, 1'b0, 5, 2};
    vecs[3] = '{8'h00, 2, 1'b0, -1, 1'b0, 0, 0};
    vecs[4] = '{8'h81, 0, 1'b0, -1, 1'b1, 2, 1};
    vecs[5] = '{8'h36, 2, 1'b0, -1, 1'b1, 8, 1};
    vecs[6] = '{8'h0C, 1, 1'b1, 6, 1'b0, 7, 3};
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.continuous = 1'b0;
    bus.chan_mask = '0;
    bus.dwell = '0;
    bus.din = 1'b0;
    #2;
    check_out("reset", 0, 0, 0, 0, 0);
    check("reset_i", int'(bus.i), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    foreach (vecs[v]) begin
      run_scan(vecs[v].mask, vecs[v].dwell, vecs[v].cont, vecs[v].stop_at, vecs[v].meddle, en_c, lp);
      check($sformatf("vec%0d_en_cycles", v), en_c, vecs[v].exp_en);
      check($sformatf("vec%0d_pass", v), lp, vecs[v].exp_pass);
    end
    // start accepted in the same cycle done is high
    bus.chan_mask = 8'h10;
    bus.dwell = 8'd2;
    bus.continuous = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_out("b2b_a0", 4, 1, 1, 0, 0);
    step();
    check_out("b2b_a1", 4, 1, 1, 0, 0);
    step();
    check_out("b2b_done", 0, 0, 0, 1, 1);
    bus.chan_mask = 8'h02;
    bus.dwell = 8'd1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_out("b2b_b0", 1, 1, 1, 0, 0);
    step();
    check_out("b2b_bdone", 0, 0, 0, 1, 1);
    step();
    check_out("b2b_idle", 0, 0, 0, 0, 1);
    // asynchronous reset in the middle of a continuous scan on channel 3
    bus.chan_mask = 8'h08;
    bus.dwell = 8'd1;
    bus.continuous = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    check_out("pre_reset", 3, 1, 1, 0, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 0, 0, 0, 0, 0);
    check("async_reset_i", int'(bus.i), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.continuous = 1'b0;
    step();
    check_out("post_reset_idle", 0, 0, 0, 0, 0);
    for (int r = 0; r < 40; r++) begin
      m = 8'($urandom);
      if (r % 8 == 0) m = 8'h00;
      len = $countones(m) * 1;
      sa = -1;
      if (r % 3 == 0 && len > 0) begin
        run_scan(m, $urandom_range(0, 4), 1'b1, $urandom_range(0, 3 * len * 2), 1'b0, en_c, lp);
      end else begin
        if (len > 0 && $urandom_range(0, 1) == 1) sa = $urandom_range(0, len - 1);
        run_scan(m, $urandom_range(0, 4), 1'b0, sa, 1'($urandom), en_c, lp);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
